simple_bus_initiator: RTL and testbench

- Single-outstanding bus initiator for the simple-system device bus (req/we/be/addr/wdata out; rvalid/rdata/err in).
- Drives peripherals such as the system control block and timer from a test sequencer, debug bridge or DMA-style engine.
- Accepts one command on a valid/ready interface, issues a one-cycle request, and waits for rvalid with a bounded timeout.
- Returns rdata/err/timeout on a valid/ready response interface.

---
 rtl/simple_bus_pkg.sv | 27 ++
 rtl/sat_counter.sv | 22 ++
 rtl/simple_bus_initiator.sv | 134 +++++++++++++
 tb/tb_simple_bus_initiator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// Shared types for the simple-system bus initiator: request/response records,
// FSM state encoding and the statistics counter width.
package simple_bus_pkg;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } bus_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } init_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear, async active-low reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/simple_bus_initiator.sv
// Single-outstanding bus initiator: command in, one-cycle request, bounded wait, response out.
// Optional event counters are built when SIMPLE_BUS_INITIATOR_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a command
//   REQ   | req_o asserted for one cycle with the captured fields
//   WAIT  | counting cycles until rvalid_i or timeout
//   RSP   | response presented until rsp_ready_i
module simple_bus_initiator
  import simple_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ADDR_ALIGN     = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        busy_o
`ifdef SIMPLE_BUS_INITIATOR_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_txn_o,
  output logic [STAT_W-1:0] stat_err_o,
  output logic [STAT_W-1:0] stat_timeout_o,
  output logic [STAT_W-1:0] stat_stray_o
`endif
);

  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYCLES);

  init_state_e r_state;
  bus_req_t    r_req;
  bus_rsp_t    r_rsp;
  logic [7:0]  r_cnt;

  logic        w_req;
  logic        w_rsp;
  logic [31:0] w_addr;

  assign w_addr = ADDR_ALIGN ? {cmd_addr_i[31:2], 2'b00} : cmd_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_rsp   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_req   <= '{we: cmd_we_i, be: cmd_be_i, addr: w_addr, wdata: cmd_wdata_i};
            r_state <= REQ;
          end
        end
        REQ: begin
          r_cnt   <= 8'd1;
          r_state <= WAIT;
        end
        WAIT: begin
          // A response arriving in the terminal cycle still wins over the timeout.
          if (rvalid_i) begin
            r_rsp   <= '{rdata: (r_req.we ? 32'd0 : rdata_i), err: err_i, timeout: 1'b0};
            r_state <= RSP;
          end else if (r_cnt == TIMEOUT_TC) begin
            r_rsp   <= '{rdata: 32'd0, err: 1'b1, timeout: 1'b1};
            r_state <= RSP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RSP: begin
          if (rsp_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_req = (r_state == REQ);
  assign w_rsp = (r_state == RSP);

  assign cmd_ready_o   = (r_state == IDLE);
  assign busy_o        = (r_state != IDLE);
  assign req_o         = w_req;
  assign we_o          = w_req & r_req.we;
  assign be_o          = w_req ? r_req.be    : 4'd0;
  assign addr_o        = w_req ? r_req.addr  : 32'd0;
  assign wdata_o       = w_req ? r_req.wdata : 32'd0;
  assign rsp_valid_o   = w_rsp;
  assign rsp_rdata_o   = w_rsp ? r_rsp.rdata : 32'd0;
  assign rsp_err_o     = w_rsp & r_rsp.err;
  assign rsp_timeout_o = w_rsp & r_rsp.timeout;

`ifdef SIMPLE_BUS_INITIATOR_STATS_EN
  logic w_hs;
  logic w_stray;

  assign w_hs    = w_rsp & rsp_ready_i;
  assign w_stray = rvalid_i & (r_state != WAIT);

  sat_counter #(.WIDTH(STAT_W)) u_stat_txn (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_hs), .clr_i(1'b0), .count_o(stat_txn_o)
  );
  sat_counter #(.WIDTH(STAT_W)) u_stat_err (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_hs & r_rsp.err), .clr_i(1'b0), .count_o(stat_err_o)
  );
  sat_counter #(.WIDTH(STAT_W)) u_stat_timeout (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_hs & r_rsp.timeout), .clr_i(1'b0),
    .count_o(stat_timeout_o)
  );
  sat_counter #(.WIDTH(STAT_W)) u_stat_stray (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(w_stray), .clr_i(1'b0), .count_o(stat_stray_o)
  );
`endif

endmodule

// File: tb/tb_simple_bus_initiator.sv
// Randomized bench for simple_bus_initiator: each transaction's expected response and timing
// come from the device latency chosen for it; counters are checked when stats are built in.
module tb_simple_bus_initiator;
  import simple_bus_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_be_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;
  logic        busy_o;
`ifdef SIMPLE_BUS_INITIATOR_STATS_EN
  logic [STAT_W-1:0] stat_txn_o, stat_err_o, stat_timeout_o, stat_stray_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int e_txn = 0, e_err = 0, e_to = 0, e_stray = 0;

  always #5 clk_i = ~clk_i;

  simple_bus_initiator #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_ALIGN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_be_i(cmd_be_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i), .busy_o(busy_o)
`ifdef SIMPLE_BUS_INITIATOR_STATS_EN
    ,
    .stat_txn_o(stat_txn_o), .stat_err_o(stat_err_o),
    .stat_timeout_o(stat_timeout_o), .stat_stray_o(stat_stray_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats();
`ifdef SIMPLE_BUS_INITIATOR_STATS_EN
    check("stat_txn", 32'(stat_txn_o), 32'(e_txn));
    check("stat_err", 32'(stat_err_o), 32'(e_err));
    check("stat_timeout", 32'(stat_timeout_o), 32'(e_to));
    check("stat_stray", 32'(stat_stray_o), 32'(e_stray));
`endif
  endtask

  // lat: device answers in the lat-th WAIT cycle; 0 or > TIMEOUT means it never answers in time.
  task automatic run_txn(input logic twe, input logic [3:0] tbe, input logic [31:0] taddr,
                         input logic [31:0] twdata, input int lat, input logic derr,
                         input logic [31:0] drd, input int bp, input bit stray_req,
                         input bit stray_rsp);
    logic [31:0] x_rd;
    logic        x_err, x_to;
    int          n_wait;
    if (lat >= 1 && lat <= TIMEOUT) begin
      x_rd = twe ? 32'd0 : drd; x_err = derr; x_to = 1'b0; n_wait = lat;
    end else begin
      x_rd = 32'd0; x_err = 1'b1; x_to = 1'b1; n_wait = TIMEOUT;
    end

    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1);
    check("busy_idle", busy_o, 0);
    cmd_valid_i = 1'b1; cmd_we_i = twe; cmd_be_i = tbe; cmd_addr_i = taddr; cmd_wdata_i = twdata;

    @(negedge clk_i);
    cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    check("req_o", req_o, 1);
    check("we_o", we_o, twe);
    check("be_o", be_o, tbe);
    check("addr_o", addr_o, {taddr[31:2], 2'b00});
    check("wdata_o", wdata_o, twdata);
    check("cmd_ready_busy", cmd_ready_o, 0);
    if (stray_req) begin
      rvalid_i = 1'b1; err_i = 1'b1; rdata_i = $urandom; e_stray++;
    end

    for (int k = 1; k <= n_wait; k++) begin
      @(negedge clk_i);
      check("req_once", req_o, 0);
      check("rsp_early", rsp_valid_o, 0);
      rvalid_i = (k == lat);
      err_i    = (k == lat) ? derr : 1'($urandom);
      rdata_i  = (k == lat) ? drd : $urandom;
    end

    @(negedge clk_i);
    rvalid_i = 1'b0;
    check("rsp_valid", rsp_valid_o, 1);
    check("rsp_rdata", rsp_rdata_o, x_rd);
    check("rsp_err", rsp_err_o, x_err);
    check("rsp_timeout", rsp_timeout_o, x_to);

    for (int b = 0; b < bp; b++) begin
      rvalid_i = stray_rsp && (b == 0);
      if (rvalid_i) e_stray++;
      cmd_valid_i = 1'b1;
      @(negedge clk_i);
      check("bp_rsp_valid", rsp_valid_o, 1);
      check("bp_rdata", rsp_rdata_o, x_rd);
      check("bp_err", rsp_err_o, x_err);
      check("bp_timeout", rsp_timeout_o, x_to);
      check("bp_cmd_ready", cmd_ready_o, 0);
      check("bp_req", req_o, 0);
    end
    rvalid_i = 1'b0; cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;

    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    e_txn++;
    if (x_err) e_err++;
    if (x_to)  e_to++;
    check("rsp_dropped", rsp_valid_o, 0);
    check("cmd_ready_after", cmd_ready_o, 1);
    check_stats();
  endtask

  task automatic idle_stray(input int gap);
    repeat (gap) @(negedge clk_i);
    rvalid_i = 1'b1; err_i = 1'b1; rdata_i = $urandom; e_stray++;
    @(negedge clk_i);
    rvalid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("stray_no_rsp", rsp_valid_o, 0);
      check("stray_idle", busy_o, 0);
    end
    check_stats();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_be_i = 4'd0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_req", req_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check_stats();

    run_txn(1'b1, 4'hF, 32'h0, 32'h1, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    run_txn(1'b0, 4'hF, 32'h4, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0);
    run_txn(1'b1, 4'hF, 32'h0, 32'h2, 1, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 4'hF, 32'h4, 32'h0, 1, 1'b0, 32'hCAFE_0001, 0, 1'b0, 1'b0);
    // Device silent: timeout, then a late response long after is ignored.
    run_txn(1'b0, 4'hF, 32'h8, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    idle_stray(4);
    run_txn(1'b0, 4'h3, 32'h13, 32'h0, 3, 1'b0, 32'hA5A5_0F0F, 5, 1'b0, 1'b1);
    run_txn(1'b0, 4'hF, 32'h20, 32'h0, TIMEOUT, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
    run_txn(1'b1, 4'h0, 32'h24, 32'h55, TIMEOUT + 1, 1'b0, 32'h0, 1, 1'b1, 1'b0);

    // Reset in the middle of WAIT.
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_be_i = 4'hF; cmd_addr_i = 32'h40;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_cmd_ready", cmd_ready_o, 1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_req", req_o, 0);
    e_txn = 0; e_err = 0; e_to = 0; e_stray = 0;
    @(negedge clk_i);
    rvalid_i = 1'b1;
    @(negedge clk_i);
    check("rst_req_held", req_o, 0);
    rvalid_i = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      @(negedge clk_i);
      check("post_rst_no_rsp", rsp_valid_o, 0);
    end
    check_stats();

    for (int t = 0; t < 150; t++) begin
      logic        r_we;
      int          r_lat;
      r_we  = 1'($urandom);
      r_lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT + 3))
                                           : int'($urandom_range(1, 4));
      run_txn(r_we, 4'($urandom), $urandom, $urandom, r_lat, 1'($urandom_range(0, 3) == 0),
              $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0) idle_stray(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
